// File: rtl/fpu_div_32bit_seq.sv
// -----------------------------------------------------------------------------
// fpu_div_32bit_seq
// Sequential IEEE-754 binary32 divider (Q = A / B), radix-2 restoring,
// one quotient bit per clock, round-to-nearest-even. Subnormal operands
// are treated as signed zero and subnormal results flush to zero.
//
// Ports
//   clk          in   1   clock, rising edge active
//   rst          in   1   synchronous reset, active-high
//   start        in   1   request, accepted only when idle
//   A            in  32   dividend (binary32), sampled at the accept edge
//   B            in  32   divisor  (binary32), sampled at the accept edge
//   busy         out  1   high whenever the block is not idle
//   done         out  1   one-cycle pulse when Q and flags first become valid
//   Q            out 32   quotient, held until the next accept edge
//   NaN, overflow, underflow, zero, div_by_zero
//                out  1   status flags, valid with done and held with Q
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fpu_div_32bit_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] Q,
   output logic        NaN,
   output logic        overflow,
   output logic        underflow,
   output logic        zero,
   output logic        div_by_zero
);

   localparam logic [4:0]  LAST_ITER = 5'd25;   // 26 iterations: count 0..25
   localparam logic [31:0] QNAN      = 32'h7FC00000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIV   = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // flag vector order: {NaN, overflow, underflow, zero, div_by_zero}
   typedef struct packed {
      logic [31:0] q;
      logic [4:0]  flags;
   } res_t;

   // Normalise the 26-bit quotient, round to nearest even, then range-check.
   function automatic res_t round_rne(input logic              sgn,
                                      input logic signed [9:0] exp_in,
                                      input logic [25:0]       quo,
                                      input logic              sticky_in);
      res_t              r;
      logic [23:0]       mant;
      logic [24:0]       sum;
      logic              guard;
      logic              sticky;
      logic              inc;
      logic signed [9:0] e;
      if (quo[25]) begin
         mant   = quo[25:2];
         guard  = quo[1];
         sticky = sticky_in | quo[0];
         e      = exp_in;
      end else begin
         mant   = quo[24:1];
         guard  = quo[0];
         sticky = sticky_in;
         e      = exp_in - 10'sd1;
      end
      inc = guard & (sticky | mant[0]);
      sum = {1'b0, mant} + {24'd0, inc};
      // carry out of the mantissa means it rounded up to 2.0
      if (sum[24]) begin
         mant = sum[24:1];
         e    = e + 10'sd1;
      end else begin
         mant = sum[23:0];
      end
      r.q     = {sgn, e[7:0], mant[22:0]};
      r.flags = 5'b00000;
      if (e >= 10'sd255) begin
         r.q     = {sgn, 8'hFF, 23'd0};
         r.flags = 5'b01000;
      end else if (e <= 10'sd0) begin
         r.q     = {sgn, 31'd0};
         r.flags = 5'b00110;
      end
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [24:0]       rem_q, rem_d;
   logic [25:0]       quo_q, quo_d;
   logic [23:0]       divs_q, divs_d;
   logic signed [9:0] exp_q, exp_d;
   logic              sign_q, sign_d;
   logic [31:0]       res_q, res_d;
   logic [4:0]        flags_q, flags_d;

   // operand classification; exponent 0 covers both zero and subnormal
   logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, s_ab;
   logic [24:0] trial;
   res_t        rnd;

   assign a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
   assign a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
   assign a_zero = (A[30:23] == 8'h00);
   assign b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
   assign b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
   assign b_zero = (B[30:23] == 8'h00);
   assign s_ab   = A[31] ^ B[31];

   assign trial = rem_q - {1'b0, divs_q};
   assign rnd   = round_rne(sign_q, exp_q, quo_q, rem_q != 25'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      divs_d  = divs_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      res_d   = res_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sign_d = s_ab;
               if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                  res_d   = QNAN;
                  flags_d = 5'b10000;
                  state_d = S_DONE;
               end else if (b_zero) begin
                  res_d   = {s_ab, 8'hFF, 23'd0};
                  flags_d = 5'b00001;
                  state_d = S_DONE;
               end else if (a_inf) begin
                  res_d   = {s_ab, 8'hFF, 23'd0};
                  flags_d = 5'b00000;
                  state_d = S_DONE;
               end else if (a_zero || b_inf) begin
                  res_d   = {s_ab, 31'd0};
                  flags_d = 5'b00010;
                  state_d = S_DONE;
               end else begin
                  rem_d   = {2'b01, A[22:0]};
                  divs_d  = {1'b1, B[22:0]};
                  quo_d   = 26'd0;
                  cnt_d   = 5'd0;
                  exp_d   = $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            // restoring step: remainder stays below 2*divisor, so 25 bits suffice
            if (rem_q >= {1'b0, divs_q}) begin
               quo_d = {quo_q[24:0], 1'b1};
               rem_d = {trial[23:0], 1'b0};
            end else begin
               quo_d = {quo_q[24:0], 1'b0};
               rem_d = {rem_q[23:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            res_d   = rnd.q;
            flags_d = rnd.flags;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         res_q   <= 32'd0;
         flags_q <= 5'd0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      divs_q <= divs_d;
      exp_q  <= exp_d;
      sign_q <= sign_d;
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign Q           = res_q;
   assign NaN         = flags_q[4];
   assign overflow    = flags_q[3];
   assign underflow   = flags_q[2];
   assign zero        = flags_q[1];
   assign div_by_zero = flags_q[0];

endmodule
